key_amount_entry: RTL and testbench

Consumer of the keypad scanner's key_value/press interface. Turns debounced key codes into a two-digit decimal charge amount. Arbitrates the start/clear/confirm keys and hands a validated amount to the charge controller with a one-cycle confirm pulse. Sits between the keypad scanner and the charge controller/display driver, in the 1000 Hz divided-clock domain.

---
 rtl/key_amount_entry_pkg.sv | 21 ++
 rtl/key_amount_entry_edge.sv | 27 ++
 rtl/key_amount_entry.sv | 154 +++++++++++++++
 tb/tb_key_amount_entry.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/key_amount_entry_pkg.sv
// Shared key codes and controller state encoding used by the keypad scanner,
// the amount-entry controller and the charge controller.
package key_amount_entry_pkg;

    localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
    localparam logic [3:0] KEY_START     = 4'd10;
    localparam logic [3:0] KEY_CLEAR     = 4'd11;
    localparam logic [3:0] KEY_CONFIRM   = 4'd12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Two BCD digits never exceed 99, so 7 bits cannot overflow.
    function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
        return 7'(tens) * 7'd10 + 7'(ones);
    endfunction

endpackage

// File: rtl/key_amount_entry_edge.sv
// Rising-edge detector on the scanner's press level; one accept strobe per
// physical key press, with the key code passed through for that cycle.
module key_edge_detect
    import key_amount_entry_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       press,
    input  logic [3:0] key_value,
    output logic       accept,
    output logic [3:0] key_sampled
);

    logic press_q;

    // Reset to 1 so a key still held through reset release is not taken.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            press_q <= 1'b1;
        else
            press_q <= press;
    end

    assign accept      = press & ~press_q;
    assign key_sampled = key_value;

endmodule

// File: rtl/key_amount_entry.sv
// Two-digit decimal charge-amount entry: keypad codes in, validated amount and
// one-cycle confirm/error strobes out.
//
// state | meaning
// IDLE  | waiting for the start key
// ENTRY | collecting up to two digits, clear/start/confirm arbitrated
// HOLD  | amount frozen for the charge controller until charge_done
module key_amount_entry
    import key_amount_entry_pkg::*;
#(
    parameter int MAX_AMOUNT = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_value,
    input  logic       press,
    input  logic       charge_done,
    output logic [6:0] amount,
    output logic [7:0] amount_bcd,
    output logic [1:0] digit_count,
    output logic       entry_active,
    output logic       confirm_pulse,
    output logic       error_pulse
);

    logic       accept;
    logic [3:0] key;

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [1:0] count_q, count_d;
    logic [6:0] amount_q, amount_d;
    logic       confirm_q, confirm_d;
    logic       error_q, error_d;

    logic is_digit;
    logic amount_ok;

    key_edge_detect u_edge (
        .clk         (clk),
        .rst_n       (rst_n),
        .press       (press),
        .key_value   (key_value),
        .accept      (accept),
        .key_sampled (key)
    );

    assign is_digit  = (key <= KEY_MAX_DIGIT);
    assign amount_ok = (amount_q != 7'd0) && (amount_q <= 7'(MAX_AMOUNT));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && key == KEY_START) state_d = ENTRY;
            ENTRY:   if (accept && key == KEY_CONFIRM && amount_ok) state_d = HOLD;
            HOLD:    if (charge_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Digit registers and strobes; charge_done in HOLD has priority over keys
    // simply because keys are never looked at in HOLD.
    always_comb begin
        tens_d    = tens_q;
        ones_d    = ones_q;
        count_d   = count_q;
        confirm_d = 1'b0;
        error_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && key == KEY_START) begin
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                    count_d = 2'd0;
                end
            end
            ENTRY: begin
                if (accept) begin
                    if (is_digit) begin
                        if (count_q < 2'd2) begin
                            tens_d  = ones_q;
                            ones_d  = key;
                            count_d = count_q + 2'd1;
                        end
                    end else if (key == KEY_CLEAR || key == KEY_START) begin
                        tens_d  = 4'd0;
                        ones_d  = 4'd0;
                        count_d = 2'd0;
                    end else if (key == KEY_CONFIRM) begin
                        if (amount_ok) begin
                            confirm_d = 1'b1;
                        end else begin
                            error_d = 1'b1;
                            if (amount_q != 7'd0) begin
                                tens_d  = 4'd0;
                                ones_d  = 4'd0;
                                count_d = 2'd0;
                            end
                        end
                    end
                end
            end
            HOLD: begin
                if (charge_done) begin
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                    count_d = 2'd0;
                end
            end
            default: begin
                tens_d  = 4'd0;
                ones_d  = 4'd0;
                count_d = 2'd0;
            end
        endcase
        amount_d = bcd_to_bin(tens_d, ones_d);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            count_q   <= 2'd0;
            amount_q  <= 7'd0;
            confirm_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            count_q   <= count_d;
            amount_q  <= amount_d;
            confirm_q <= confirm_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        amount        = amount_q;
        amount_bcd    = {tens_q, ones_q};
        digit_count   = count_q;
        entry_active  = (state_q == ENTRY);
        confirm_pulse = confirm_q;
        error_pulse   = error_q;
    end

endmodule

// File: tb/tb_key_amount_entry.sv
// Directed bench for key_amount_entry with hand-computed expectations.
module tb_key_amount_entry;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_value;
    logic       press;
    logic       charge_done;
    logic [6:0] amount;
    logic [7:0] amount_bcd;
    logic [1:0] digit_count;
    logic       entry_active;
    logic       confirm_pulse;
    logic       error_pulse;

    int tests_run = 0;
    int tests_failed = 0;

    logic cp, ep;

    key_amount_entry #(.MAX_AMOUNT(20)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_value     (key_value),
        .press         (press),
        .charge_done   (charge_done),
        .amount        (amount),
        .amount_bcd    (amount_bcd),
        .digit_count   (digit_count),
        .entry_active  (entry_active),
        .confirm_pulse (confirm_pulse),
        .error_pulse   (error_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One press/release; cp/ep captured in the cycle right after acceptance.
    task automatic pk(input logic [3:0] k, output logic cp_o, output logic ep_o);
        key_value = k;
        press     = 1'b1;
        tick();
        cp_o  = confirm_pulse;
        ep_o  = error_pulse;
        press = 1'b0;
        tick();
    endtask

    task automatic chk_state(input string tag, input logic [6:0] a, input logic [7:0] b,
                             input logic [1:0] c, input logic e);
        chk({tag, "_amount"}, 32'(amount), 32'(a));
        chk({tag, "_bcd"},    32'(amount_bcd), 32'(b));
        chk({tag, "_count"},  32'(digit_count), 32'(c));
        chk({tag, "_entry"},  32'(entry_active), 32'(e));
    endtask

    initial begin
        rst_n       = 1'b1;
        press       = 1'b1;
        key_value   = 4'd10;
        charge_done = 1'b0;
        #2;
        chk_state("reset", 7'd0, 8'h00, 2'd0, 1'b0);
        chk("reset_cp", 32'(confirm_pulse), 32'd0);
        chk("reset_ep", 32'(error_pulse), 32'd0);
        tick(); tick();
        rst_n = 1'b0;
        tick(); tick(); tick();
        chk_state("held_start", 7'd0, 8'h00, 2'd0, 1'b0);
        press = 1'b0;
        tick();

        pk(4'd5, cp, ep);
        chk_state("idle_digit", 7'd0, 8'h00, 2'd0, 1'b0);
        pk(4'd10, cp, ep);
        chk_state("start", 7'd0, 8'h00, 2'd0, 1'b1);
        pk(4'd1, cp, ep);
        chk_state("d1", 7'd1, 8'h01, 2'd1, 1'b1);
        pk(4'd5, cp, ep);
        chk_state("d15", 7'd15, 8'h15, 2'd2, 1'b1);
        pk(4'd7, cp, ep);
        chk_state("third_digit", 7'd15, 8'h15, 2'd2, 1'b1);

        charge_done = 1'b1;
        tick();
        charge_done = 1'b0;
        chk_state("cd_in_entry", 7'd15, 8'h15, 2'd2, 1'b1);

        pk(4'd12, cp, ep);
        chk("conf15_cp", 32'(cp), 32'd1);
        chk("conf15_ep", 32'(ep), 32'd0);
        chk("conf15_cp_end", 32'(confirm_pulse), 32'd0);
        chk_state("hold", 7'd15, 8'h15, 2'd2, 1'b0);
        pk(4'd3, cp, ep);
        pk(4'd11, cp, ep);
        pk(4'd10, cp, ep);
        pk(4'd12, cp, ep);
        chk("hold_conf_cp", 32'(cp), 32'd0);
        chk("hold_conf_ep", 32'(ep), 32'd0);
        chk_state("hold_keys", 7'd15, 8'h15, 2'd2, 1'b0);

        key_value   = 4'd10;
        press       = 1'b1;
        charge_done = 1'b1;
        tick();
        charge_done = 1'b0;
        chk_state("cd_start", 7'd0, 8'h00, 2'd0, 1'b0);
        press = 1'b0;
        tick(); tick();
        chk_state("start_discarded", 7'd0, 8'h00, 2'd0, 1'b0);

        pk(4'd10, cp, ep);
        pk(4'd2, cp, ep);
        pk(4'd5, cp, ep);
        chk_state("d25", 7'd25, 8'h25, 2'd2, 1'b1);
        pk(4'd12, cp, ep);
        chk("conf25_ep", 32'(ep), 32'd1);
        chk("conf25_cp", 32'(cp), 32'd0);
        chk("conf25_ep_end", 32'(error_pulse), 32'd0);
        chk_state("after25", 7'd0, 8'h00, 2'd0, 1'b1);

        pk(4'd12, cp, ep);
        chk("conf0_ep", 32'(ep), 32'd1);
        chk("conf0_cp", 32'(cp), 32'd0);
        chk_state("after0", 7'd0, 8'h00, 2'd0, 1'b1);
        pk(4'd0, cp, ep);
        chk_state("lead0", 7'd0, 8'h00, 2'd1, 1'b1);
        pk(4'd8, cp, ep);
        chk_state("d08", 7'd8, 8'h08, 2'd2, 1'b1);

        pk(4'd11, cp, ep);
        chk_state("clear", 7'd0, 8'h00, 2'd0, 1'b1);
        key_value = 4'd4;
        press     = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        press = 1'b0;
        tick();
        chk_state("held_digit", 7'd4, 8'h04, 2'd1, 1'b1);
        pk(4'd13, cp, ep);
        pk(4'd14, cp, ep);
        pk(4'd15, cp, ep);
        chk_state("unused_codes", 7'd4, 8'h04, 2'd1, 1'b1);
        pk(4'd2, cp, ep);
        chk_state("d42", 7'd42, 8'h42, 2'd2, 1'b1);
        pk(4'd10, cp, ep);
        chk_state("start_clears", 7'd0, 8'h00, 2'd0, 1'b1);

        pk(4'd2, cp, ep);
        pk(4'd1, cp, ep);
        pk(4'd12, cp, ep);
        chk("conf21_ep", 32'(ep), 32'd1);
        chk("conf21_cp", 32'(cp), 32'd0);
        chk_state("after21", 7'd0, 8'h00, 2'd0, 1'b1);
        pk(4'd2, cp, ep);
        pk(4'd0, cp, ep);
        pk(4'd12, cp, ep);
        chk("conf20_cp", 32'(cp), 32'd1);
        chk("conf20_ep", 32'(ep), 32'd0);
        chk_state("hold20", 7'd20, 8'h20, 2'd2, 1'b0);
        charge_done = 1'b1;
        tick();
        charge_done = 1'b0;
        chk_state("done20", 7'd0, 8'h00, 2'd0, 1'b0);

        pk(4'd10, cp, ep);
        pk(4'd9, cp, ep);
        chk_state("d9", 7'd9, 8'h09, 2'd1, 1'b1);
        #2;
        rst_n = 1'b1;
        #1;
        chk_state("mid_reset", 7'd0, 8'h00, 2'd0, 1'b0);
        chk("mid_reset_cp", 32'(confirm_pulse), 32'd0);
        chk("mid_reset_ep", 32'(error_pulse), 32'd0);
        tick();
        rst_n = 1'b0;
        tick();
        chk_state("post_reset", 7'd0, 8'h00, 2'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
